// File: rtl/canny_win_ctrl.sv
// canny_win_ctrl
// Sequencer for the Canny 3x3 window generator (two-tap line buffer plus a
// 3x3 register matrix). It follows the raster position of the incoming pixel
// stream, gates the line-buffer shift enable, flags the cycles in which the
// matrix holds a complete interior window, and reports the window centre.
// Mid-line stream gaps are trapped in an error state. A one-cycle pulse marks
// the end of the frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse that arms a new frame (from IDLE or ERR)
//   din_vld    source pixel valid
//   shift_en   combinational line-buffer/matrix enable (accepted pixel)
//   busy       registered, high while priming or running
//   win_vld    registered, matrix holds a complete interior window
//   win_row    registered centre row of the current window
//   win_col    registered centre column of the current window
//   frame_done registered one-cycle pulse after the last pixel
//   line_err   registered sticky flag, din_vld dropped mid-line
module canny_win_ctrl #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 768,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din_vld,
  output logic          shift_en,
  output logic          busy,
  output logic          win_vld,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          frame_done,
  output logic          line_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PRIMED = RW'(1);
  localparam logic [RW-1:0] ROW_TWO    = RW'(2);
  localparam logic [CW-1:0] COL_TWO    = CW'(2);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          win_vld_q, win_vld_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          frame_done_q, frame_done_d;
  logic          line_err_q, line_err_d;
  logic          busy_q, busy_d;
  logic          accept;

  // A pixel is consumed only while the sequencer is priming or running. The
  // same signal clocks the line buffer, so it must stay combinational to line
  // up with the pixel that is being accepted.
  always_comb begin
    accept = din_vld & ((state_q == S_PRIME) | (state_q == S_RUN));
  end

  assign shift_en   = accept;
  assign busy       = busy_q;
  assign win_vld    = win_vld_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

  // Next-state and next-output logic. The raster counters move only on
  // accepted pixels. A pixel at (r,c) with r>=2 and c>=2 completes the window
  // centred at (r-1,c-1), and the matrix shows it on the following cycle.
  // While a line is partly received (col != 0), a missing pixel would shift
  // stale data into the free-running matrix, so the frame is abandoned into
  // ERR. A gap at col 0 (between lines) is harmless.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    win_vld_d    = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          row_d   = '0;
          col_d   = '0;
        end
      end

      S_PRIME, S_RUN: begin
        if (accept) begin
          if ((row_q >= ROW_TWO) && (col_q >= COL_TWO)) begin
            win_vld_d = 1'b1;
            win_row_d = row_q - RW'(1);
            win_col_d = col_q - CW'(1);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if ((state_q == S_PRIME) && (row_q == ROW_PRIMED) && (col_q == COL_LAST)) begin
            state_d = S_RUN;
          end
          // Clearing the row here avoids overflowing a counter whose width
          // exactly fits IMG_H rows.
          if ((state_q == S_RUN) && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
            row_d        = '0;
          end
        end else if (col_q != '0) begin
          state_d    = S_ERR;
          line_err_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        if (start) begin
          state_d    = S_PRIME;
          line_err_d = 1'b0;
          row_d      = '0;
          col_d      = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PRIME) | (state_d == S_RUN);
  end

  // State and output registers. Reset takes effect on the clock edge, so a
  // frame in progress is abandoned immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_vld_q    <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_vld_q    <= win_vld_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_canny_win_ctrl.sv
// Testbench for canny_win_ctrl. It uses an 8x5 instance for the main checks
// and a 3x3 instance for the minimum-size frame. Each expected window
// (centre and due cycle) is queued when its completing pixel is driven, and
// the queue is drained when win_vld appears.
module tb_canny_win_ctrl;

  localparam int W = 8;
  localparam int H = 5;

  logic       clk;
  logic       rst;
  logic       start_a, din_a;
  logic       shift_en_a, busy_a, win_vld_a, frame_done_a, line_err_a;
  logic [2:0] win_row_a, win_col_a;
  logic       start_b, din_b;
  logic       shift_en_b, busy_b, win_vld_b, frame_done_b, line_err_b;
  logic [1:0] win_row_b, win_col_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int win_cnt_b = 0;
  int done_cnt_b = 0;
  logic [2:0] hold_row = '0;
  logic [2:0] hold_col = '0;

  typedef struct {
    int row;
    int col;
    int due;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic rst;
    logic start;
    logic din;
    logic exp_shift;
    logic exp_busy;
    logic exp_lerr;
  } vec_t;
  vec_t tbl[10];

  canny_win_ctrl #(.IMG_W(W), .IMG_H(H)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din_vld(din_a),
    .shift_en(shift_en_a), .busy(busy_a), .win_vld(win_vld_a),
    .win_row(win_row_a), .win_col(win_col_a),
    .frame_done(frame_done_a), .line_err(line_err_a)
  );

  canny_win_ctrl #(.IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din_vld(din_b),
    .shift_en(shift_en_b), .busy(busy_b), .win_vld(win_vld_b),
    .win_row(win_row_b), .win_col(win_col_b),
    .frame_done(frame_done_b), .line_err(line_err_b)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp used to check the exact latency of every window.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8x5 instance, sampled just after each rising edge. Each
  // window must match the head of the queue in both position and cycle.
  // Between windows the coordinates must hold. frame_done must coincide with
  // the last window while busy drops.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      check_output("reset_outs", {20'd0, win_vld_a, frame_done_a, busy_a, line_err_a, win_row_a, win_col_a}, 32'd0);
      sb_q.delete();
      hold_row = '0;
      hold_col = '0;
    end else if (win_vld_a) begin
      if (sb_q.size() == 0) begin
        check_output("spurious_win", {31'd0, win_vld_a}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_output("win_time", cyc, e.due);
        check_output("win_coord", {26'd0, win_row_a, win_col_a}, {26'd0, 3'(e.row), 3'(e.col)});
        hold_row = 3'(e.row);
        hold_col = 3'(e.col);
        win_cnt++;
      end
    end else begin
      check_output("win_hold", {26'd0, win_row_a, win_col_a}, {26'd0, hold_row, hold_col});
    end
    if (frame_done_a) begin
      check_output("done_align", {24'd0, win_vld_a, busy_a, win_row_a, win_col_a},
                   {24'd0, 1'b1, 1'b0, 3'(H - 2), 3'(W - 2)});
      done_cnt++;
    end
  end

  // Monitor for the 3x3 instance: its single window is centred at (1,1) and
  // lands together with frame_done.
  always @(posedge clk) begin
    #2;
    if (!rst && win_vld_b) begin
      check_output("min_win", {28'd0, win_row_b, win_col_b, frame_done_b}, {28'd0, 2'd1, 2'd1, 1'b1});
      win_cnt_b++;
    end
    if (!rst && frame_done_b) done_cnt_b++;
  end

  // Drives one 8x5 frame starting from the current falling edge. mode 0 runs
  // to completion, mode 1 drops din_vld at (er,ec), and mode 2 asserts reset
  // at (er,ec). The task returns one idle cycle after the DONE cycle, so an
  // immediate follow-on call issues start while the DUT is back in IDLE.
  task automatic apply_stimulus(input int gap, input int mode, input int er, input int ec,
                                input bit coinc, input bit start_in_run);
    start_a = 1'b1;
    din_a   = coinc;
    @(negedge clk);
    start_a = 1'b0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        start_a = start_in_run && (r == 3) && (c == 0);
        if (mode == 1 && r == er && c == ec) begin
          din_a = 1'b0;
          @(posedge clk);
          #1;
          check_output("gap_line_err", {30'd0, line_err_a, busy_a}, {30'd0, 1'b1, 1'b0});
          @(negedge clk);
          for (int k = 0; k < 4; k++) begin
            din_a = 1'b1;
            #1;
            check_output("err_shift_en", {31'd0, shift_en_a}, 32'd0);
            @(negedge clk);
          end
          din_a = 1'b0;
          return;
        end
        if (mode == 2 && r == er && c == ec) begin
          rst   = 1'b1;
          din_a = 1'b1;
          @(posedge clk);
          #1;
          check_output("rst_busy_lerr", {30'd0, busy_a, line_err_a}, 32'd0);
          @(negedge clk);
          rst   = 1'b0;
          din_a = 1'b1;
          #1;
          check_output("rst_shift_en", {31'd0, shift_en_a}, 32'd0);
          @(negedge clk);
          din_a = 1'b0;
          return;
        end
        din_a = 1'b1;
        if (r >= 2 && c >= 2) sb_q.push_back('{row: r - 1, col: c - 1, due: cyc + 1});
        @(negedge clk);
      end
      for (int g = 0; g < gap; g++) begin
        din_a   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
      end
    end
    start_a = 1'b0;
    din_a   = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int w0, input int d0);
    check_output({name, "_windows"}, win_cnt - w0, (H - 2) * (W - 2));
    check_output({name, "_done"}, done_cnt - d0, 1);
    check_output({name, "_queue"}, sb_q.size(), 0);
    check_output({name, "_lerr"}, {31'd0, line_err_a}, 32'd0);
  endtask

  initial begin
    int w0, d0;
    rst = 1'b1;
    start_a = 1'b0;
    din_a = 1'b0;
    start_b = 1'b0;
    din_b = 1'b0;

    // The table rows are rst, start, din_vld, then the expected shift_en
    // before the edge, and the expected busy and line_err after it.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      rst     = tbl[i].rst;
      start_a = tbl[i].start;
      din_a   = tbl[i].din;
      #1;
      check_output($sformatf("vec%0d_shift_en", i), {31'd0, shift_en_a}, {31'd0, tbl[i].exp_shift});
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_busy", i), {31'd0, busy_a}, {31'd0, tbl[i].exp_busy});
      check_output($sformatf("vec%0d_line_err", i), {31'd0, line_err_a}, {31'd0, tbl[i].exp_lerr});
      @(negedge clk);
    end
    rst = 1'b0;
    start_a = 1'b0;
    din_a = 1'b0;
    @(negedge clk);

    $display("[TB] nominal frame");
    w0 = win_cnt; d0 = done_cnt;
    apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
    check_frame("nominal", w0, d0);

    $display("[TB] inter-line gaps");
    w0 = win_cnt; d0 = done_cnt;
    apply_stimulus(3, 0, 0, 0, 1'b0, 1'b0);
    check_frame("gaps", w0, d0);

    $display("[TB] mid-line gap at (2,4)");
    w0 = win_cnt;
    apply_stimulus(0, 1, 2, 4, 1'b0, 1'b0);
    check_output("err_windows", win_cnt - w0, 2);
    check_output("err_queue", sb_q.size(), 0);
    w0 = win_cnt; d0 = done_cnt;
    apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
    check_frame("after_err", w0, d0);

    $display("[TB] reset at (3,5)");
    apply_stimulus(0, 2, 3, 5, 1'b0, 1'b0);
    check_output("rst_queue", sb_q.size(), 0);

    $display("[TB] start coincident with din_vld, start during run, back-to-back");
    w0 = win_cnt; d0 = done_cnt;
    apply_stimulus(0, 0, 0, 0, 1'b1, 1'b1);
    check_frame("coinc_run", w0, d0);
    w0 = win_cnt; d0 = done_cnt;
    apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
    check_frame("back2back", w0, d0);

    $display("[TB] minimum 3x3 frame");
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int p = 0; p < 9; p++) begin
      din_b = 1'b1;
      #1;
      check_output("min_shift_en", {31'd0, shift_en_b}, 32'd1);
      @(negedge clk);
    end
    din_b = 1'b0;
    repeat (2) @(negedge clk);
    check_output("min_windows", win_cnt_b, 1);
    check_output("min_done", done_cnt_b, 1);
    check_output("min_idle", {30'd0, busy_b, line_err_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/canny_win_ctrl.md
Name: canny_win_ctrl

Overview:
- Sequencer for the Canny 3x3 window generator, which is built from a two-tap line buffer plus a 3x3 register matrix.
- Tracks the raster position of the incoming pixel stream and gates the line-buffer shift enable.
- Flags the cycles where the 3x3 matrix holds a complete interior window, and reports the window-centre coordinates.
- Detects mid-line stream gaps, which would corrupt the free-running matrix, and signals frame completion.
- Sits between the pixel source and the window generator; downstream Sobel/NMS stages qualify data with win_vld.

Parameters:
- IMG_W, 1024, pixels per line; must match the line-buffer tap length; minimum 3.
- IMG_H, 768, lines per frame; minimum 3.
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse to arm a new frame.
- din_vld  in  1  source pixel valid; a pixel is accepted on each cycle din_vld=1 while the state is PRIME or RUN.
- shift_en  out  1  combinational; drives the window generator's din_vld/clken; equals din_vld & (state==PRIME | state==RUN).
- busy  out  1  registered; 1 in PRIME and RUN.
- win_vld  out  1  registered; 3x3 matrix holds a complete interior window this cycle.
- win_row  out  RW  registered; centre row of the current window.
- win_col  out  CW  registered; centre column of the current window.
- frame_done  out  1  registered one-cycle pulse after the last pixel of a frame is accepted.
- line_err  out  1  registered sticky flag: din_vld dropped mid-line.

Behaviour:
- Reset: state=IDLE; row, col, win_vld, win_row, win_col, frame_done, line_err, busy all 0. Reset mid-frame aborts immediately; the line-buffer contents are don't-care.
- States:
  - IDLE: start -> PRIME, row=col=0.
  - PRIME: rows 0..1.
  - RUN: rows 2..IMG_H-1.
  - DONE: one cycle, frame_done=1, then -> IDLE.
  - ERR: holds; start -> PRIME with line_err cleared, row=col=0.
- Counters advance only on accepted pixels. col wraps IMG_W-1 -> 0 and increments row at the wrap.
  - PRIME -> RUN when the pixel at (1, IMG_W-1) is accepted.
  - RUN -> DONE when the pixel at (IMG_H-1, IMG_W-1) is accepted.
- Window timing: the matrix registers update every clk.
  - For a pixel accepted at (r,c) with r>=2 and c>=2, the next cycle has win_vld=1, win_row=r-1, win_col=c-1, aligned with the matrix outputs.
  - Every other cycle has win_vld=0; win_row and win_col hold their last value.
  - Per frame: exactly (IMG_H-2)*(IMG_W-2) win_vld pulses.
- Continuity rule: within a line, pixels must arrive on consecutive cycles.
  - If din_vld=0 while in PRIME/RUN with col in 1..IMG_W-1 (a line is partially received), the next state is ERR and line_err=1.
  - No win_vld is issued for that cycle or afterwards.
  - Gaps at col==0 (between lines or before the first pixel) are legal and have no effect.
- start in PRIME, RUN or DONE is ignored. start and din_vld in the same cycle in IDLE: that din_vld is not accepted; the first pixel is accepted the following cycle.
- din_vld in IDLE, DONE or ERR is ignored and shift_en=0.
- frame_done and the final win_vld (centre IMG_H-2, IMG_W-2) are asserted in the same cycle.
- busy=0 in the DONE cycle; start in IDLE the cycle after DONE is accepted (back-to-back frames).

Test Plan:
- Nominal frame, IMG_W=8, IMG_H=5, start then 40 contiguous din_vld -> exactly 18 win_vld pulses. First pulse is 1 cycle after pixel (2,2), with win_row=1, win_col=1. The last pulse has win_row=3, win_col=6 and coincides with frame_done. busy falls in the same cycle.
- Inter-line gaps, same params, 3 idle cycles after every line -> identical 18 windows and coordinates; line_err stays 0.
- Mid-line gap: drop din_vld at (2,4) -> line_err=1 next cycle, state ERR, no further win_vld, shift_en=0. A following start clears line_err and a clean frame then yields 18 windows.
- Reset mid-frame: rst high at (3,5) -> next cycle all outputs 0, state IDLE. din_vld without start produces shift_en=0.
- start/din_vld corner cases:
  - start during RUN -> ignored; counters continue.
  - start coincident with din_vld in IDLE -> that pixel is not counted.
  - start in the cycle after frame_done -> second frame produces 18 windows.
- Minimum size IMG_W=3, IMG_H=3 -> exactly 1 win_vld, at win_row=1, win_col=1, coincident with frame_done.
